// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op codes and helpers shared by the logic_gate_pipe slice.
// Maps each op onto a base reduction plus inversion / accumulation flags.
package logic_gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_ACC_OR = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        RED_AND = 2'd0,
        RED_OR  = 2'd1,
        RED_XOR = 2'd2
    } red_sel_t;

    function automatic logic is_inverting(input logic [OP_W-1:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic is_acc(input logic [OP_W-1:0] op);
        return op == OP_ACC_OR;
    endfunction

    // Reserved op and ACC_OR both reduce with OR.
    function automatic red_sel_t red_sel(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_NAND: return RED_AND;
            OP_XOR, OP_XNOR: return RED_XOR;
            default:         return RED_OR;
        endcase
    endfunction

endpackage

// File: rtl/logic_gate_pipe_reduce.sv
// logic_reduce: combinational AND/OR/XOR reduction across NUM_IN operands.
// Inversion and accumulation are applied by the caller.
module logic_reduce #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0]  data,
    input  logic_gate_pkg::red_sel_t sel,
    output logic [WIDTH-1:0]         result
);
    import logic_gate_pkg::*;

    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [WIDTH-1:0] r_xor;

    // Fold every operand into all three reductions.
    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            r_and = r_and & data[k*WIDTH +: WIDTH];
            r_or  = r_or  | data[k*WIDTH +: WIDTH];
            r_xor = r_xor ^ data[k*WIDTH +: WIDTH];
        end
    end

    // Pick the requested reduction.
    always_comb begin
        result = r_or;
        case (sel)
            RED_AND: result = r_and;
            RED_XOR: result = r_xor;
            default: result = r_or;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready N-input bitwise logic unit.
// Stage 1 holds the raw beat; stage 2 holds the registered result.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IN*WIDTH-1:0]         in_data,
    input  logic [logic_gate_pkg::OP_W-1:0] in_op,
    input  logic                            in_last,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_any,
    output logic                            out_valid,
    input  logic                            out_ready
);
    import logic_gate_pkg::*;

    logic                      s1_valid;
    logic [NUM_IN*WIDTH-1:0]   s1_data;
    logic [OP_W-1:0]           s1_op;
    logic                      s1_last;

    logic [WIDTH-1:0]          acc;
    logic                      acc_active;

    logic                      s1_is_acc;
    logic                      s1_absorb;
    logic                      s2_free;
    logic                      s1_adv;
    logic                      s2_load;
    logic [WIDTH-1:0]          s1_red;
    logic [WIDTH-1:0]          s1_res;
    red_sel_t                  s1_sel;

    assign s1_is_acc = is_acc(s1_op);
    assign s1_sel    = red_sel(s1_op);

    // A non-final ACC beat only feeds the accumulator, so it never waits on stage 2.
    assign s1_absorb = s1_valid & s1_is_acc & ~s1_last;
    assign s2_free   = ~out_valid | out_ready;
    assign s1_adv    = s1_valid & (s1_absorb | s2_free);
    assign s2_load   = s1_valid & ~s1_absorb & s2_free;
    assign in_ready  = ~s1_valid | s1_adv;

    logic_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .data   (s1_data),
        .sel    (s1_sel),
        .result (s1_red)
    );

    // Apply inversion or merge the running accumulator into the final ACC beat.
    always_comb begin
        s1_res = s1_red;
        if (is_inverting(s1_op)) begin
            s1_res = ~s1_red;
        end else if (s1_is_acc) begin
            s1_res = (acc & {WIDTH{acc_active}}) | s1_red;
        end
    end

    // Stage 1: capture the offered beat whenever there is room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_op    <= OP_AND;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_op   <= in_op;
                s1_last <= in_last;
            end
        end
    end

    // Accumulator: grows on non-final ACC beats, cleared by anything else leaving stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            acc_active <= 1'b0;
        end else if (s1_adv) begin
            if (s1_absorb) begin
                acc        <= (acc & {WIDTH{acc_active}}) | s1_red;
                acc_active <= 1'b1;
            end else begin
                acc        <= '0;
                acc_active <= 1'b0;
            end
        end
    end

    // Stage 2: output register, held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_any   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= s1_res;
            out_any   <= |s1_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed and random checks of logic_gate_pipe
// against a queue-based reference model.
module tb_logic_gate_pipe;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [2:0]     in_op;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_any;
    logic           out_valid;
    logic           out_ready;

    logic_gate_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_any   (out_any),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           acc_cnt = 0;
    bit           strict = 0;
    bit           use_model = 0;
    bit           pend = 0;
    bit           got = 0;
    bit           stall_prev = 0;
    logic [W-1:0] pend_d;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] prev_d;
    logic         prev_any;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_red(input logic [N*W-1:0] d,
                                               input int op);
        logic [W-1:0] a, o, x, v;
        a = '1; o = '0; x = '0;
        for (int k = 0; k < N; k++) begin
            v = d[k*W +: W];
            a = a & v; o = o | v; x = x ^ v;
        end
        case (op)
            0: return a;
            1: return o;
            2: return x;
            3: return ~a;
            4: return ~o;
            5: return ~x;
            default: return o;
        endcase
    endfunction

    task automatic model_accept();
        logic [W-1:0] r;
        r = model_red(in_data, int'(in_op));
        if (in_op == 3'd6) begin
            if (in_last) begin
                q.push_back('{m_acc | r, cyc});
                m_acc = '0;
            end else begin
                m_acc = m_acc | r;
            end
        end else begin
            m_acc = '0;
            q.push_back('{r, cyc});
        end
    endtask

    task automatic tick();
        exp_t e;
        got = 0;
        @(negedge clk);
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_d);
            chk("hold_any", out_any, prev_any);
        end
        if (in_valid && in_ready) begin
            got = 1;
            acc_cnt++;
            if (use_model) model_accept();
            else if (pend) begin
                q.push_back('{pend_d, cyc});
                pend = 0;
            end
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_any", out_any, |e.d);
                if (strict) chk("latency", cyc, e.c + 2);
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_any = out_any;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat(input logic [N*W-1:0] d, input int op,
                        input bit last, input bit has_exp,
                        input logic [W-1:0] e);
        in_data = d;
        in_op = op[2:0];
        in_last = last;
        in_valid = 1'b1;
        pend = has_exp;
        pend_d = e;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (got) break;
        end
        chk("accept_timeout", got, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        pend = 0;
        repeat (n) tick();
    endtask

    initial begin
        int start;
        rst = 1'b1;
        in_data = '0;
        in_op = '0;
        in_last = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_any", out_any, 0);
        chk("rst_in_ready", in_ready, 1);

        strict = 1;
        start = cyc;
        beat(32'h0FFF3CF0, 0, 0, 1, 8'h00);
        beat(32'h0FFF3CF0, 1, 0, 1, 8'hFF);
        beat(32'h0FFF3CF0, 2, 0, 1, 8'h3C);
        beat(32'h0FFF3CF0, 3, 0, 1, 8'hFF);
        beat(32'h0FFF3CF0, 4, 0, 1, 8'h00);
        beat(32'h0FFF3CF0, 5, 0, 1, 8'hC3);
        chk("throughput", cyc - start, 6);
        idle(3);
        chk("ops_drain", q.size(), 0);
        strict = 0;

        use_model = 1;
        m_acc = '0;
        out_ready = 1'b0;
        acc_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            in_op = 3'($urandom_range(0, 5));
            in_last = 1'b0;
            tick();
        end
        chk("stall_accepts", acc_cnt, 2);
        chk("stall_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("stall_drain", q.size(), 0);
        use_model = 0;

        strict = 1;
        beat(32'h00000001, 6, 0, 0, 8'h00);
        beat(32'h00000002, 6, 0, 0, 8'h00);
        beat(32'h00000080, 6, 1, 1, 8'h83);
        idle(3);
        chk("acc_drain", q.size(), 0);

        beat(32'h00000001, 6, 0, 0, 8'h00);
        beat(32'hFFFFFFFF, 0, 0, 1, 8'hFF);
        beat(32'h00000002, 6, 1, 1, 8'h02);
        idle(3);
        chk("acc_abort_drain", q.size(), 0);

        beat(32'h08040201, 7, 0, 1, 8'h0F);
        beat(32'h00000000, 1, 0, 1, 8'h00);
        idle(3);
        chk("misc_drain", q.size(), 0);
        strict = 0;

        use_model = 1;
        in_valid = 1'b1;
        in_op = 3'd1;
        in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom | 32'h1;
            tick();
        end
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_any", out_any, 0);
        q.delete();
        m_acc = '0;
        stall_prev = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        chk("postrst_in_ready", in_ready, 1);
        idle(4);
        chk("postrst_no_out", out_valid, 0);

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            in_op = 3'($urandom_range(0, 7));
            in_last = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("random_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
